i2c_config_seq: RTL and testbench

- Table-driven I2C configuration sequencer; parametrised successor to the fixed 20-entry config block.
- Walks an external configuration ROM (async read) and issues each WRITE entry to the byte-level I2C controller through a start/ready/end handshake.
- Adds what the fixed block lacks: DELAY and END opcodes, bounded retry on NACK, restart on request, and error index reporting.
- Sits between the configuration ROM and i2c_controller on the REF_CLK domain.

---
 rtl/i2c_cfg_pkg.sv | 33 +++
 rtl/i2c_config_seq_if.sv | 27 ++
 rtl/cfg_tick_timer.sv | 46 ++++
 rtl/i2c_config_seq.sv | 160 ++++++++++++++++
 tb/tb_i2c_config_seq.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_cfg_pkg.sv
// Shared opcodes, sequencer state encoding and width helpers for the
// table-driven I2C configuration sequencer.
package i2c_cfg_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_DELAY = 2'b01,
        OP_END   = 2'b10,
        OP_NOP   = 2'b11
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RDY,
        S_ISSUE,
        S_WAIT_END,
        S_RWAIT,
        S_DLY,
        S_ADV,
        S_DONE,
        S_FAIL
    } state_e;

    function automatic int entry_w(int reg_bytes, int data_bytes);
        return 2 + 8 * (reg_bytes + data_bytes);
    endfunction

    function automatic int cfg_w(int reg_bytes, int data_bytes);
        return 8 * (1 + reg_bytes + data_bytes);
    endfunction

endpackage

// File: rtl/i2c_config_seq_if.sv
// Byte-level I2C controller handshake: the sequencer is the master side,
// the controller the slave side.
interface i2c_config_seq_if #(
    parameter int CFG_W = 24
) ();
    logic [CFG_W-1:0] CFG_DATA;
    logic             CFG_START;
    logic             CFG_READY;
    logic             CFG_END;
    logic             CFG_NACK;

    modport master (
        output CFG_DATA,
        output CFG_START,
        input  CFG_READY,
        input  CFG_END,
        input  CFG_NACK
    );

    modport slave (
        input  CFG_DATA,
        input  CFG_START,
        output CFG_READY,
        output CFG_END,
        output CFG_NACK
    );
endinterface

// File: rtl/cfg_tick_timer.sv
// Tick prescaler plus N-tick down-counter; load restarts both so a wait of
// N ticks lasts exactly N*TICK_CYCLES cycles after the load.
module cfg_tick_timer #(
    parameter int TICK_CYCLES = 50000,
    parameter int N_W         = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [N_W-1:0] n_i,
    output logic           expired_o
);
    localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [N_W-1:0]   cnt_q, cnt_d;
    logic             tick;

    assign tick = (pre_q == PRE_W'(TICK_CYCLES - 1));

    always_comb begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        cnt_d = cnt_q;
        if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - N_W'(1);
        end
        if (load_i) begin
            pre_d = '0;
            cnt_d = n_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    // Report expiry in the cycle of the last tick so the caller leaves on time.
    assign expired_o = (cnt_q == '0) || (tick && (cnt_q == N_W'(1)));

endmodule

// File: rtl/i2c_config_seq.sv
// Walks a configuration ROM and issues WRITE entries to the I2C byte
// controller, with DELAY/END/NOP opcodes, bounded NACK retry and error index.
//   state    | meaning
//   IDLE     | waiting for START          FETCH    | decode TABLE_ENTRY
//   WAIT_RDY | wait for controller idle   ISSUE    | CFG_START pulse
//   WAIT_END | transfer in flight         RWAIT    | back-off before retry
//   DLY      | DELAY opcode wait          ADV      | next index / table end
//   DONE     | table finished             FAIL     | retries exhausted
module i2c_config_seq
    import i2c_cfg_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR  = 8'h72,
    parameter int         REG_BYTES   = 1,
    parameter int         DATA_BYTES  = 1,
    parameter int         NUM_ENTRIES = 32,
    parameter int         MAX_RETRY   = 3,
    parameter int         TICK_CYCLES = 50000,
    parameter int         RETRY_TICKS = 1,
    parameter bit         AUTO_START  = 1'b1,
    localparam int        IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    localparam int        ENTRY_W     = entry_w(REG_BYTES, DATA_BYTES),
    localparam int        CFG_W       = cfg_w(REG_BYTES, DATA_BYTES)
) (
    input  logic               REF_CLK,
    input  logic               RESET_CONFIG,
    input  logic               START,
    output logic [IDX_W-1:0]   TABLE_INDEX,
    input  logic [ENTRY_W-1:0] TABLE_ENTRY,
    i2c_config_seq_if.master   cfg,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERROR,
    output logic [IDX_W-1:0]   ERR_INDEX
);
    localparam int PAY_W = ENTRY_W - 2;
    localparam int RC_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic [RC_W-1:0]    retry_q, retry_d;
    logic [CFG_W-1:0]   cfg_data_q, cfg_data_d;
    logic               tmr_load;
    logic [PAY_W-1:0]   tmr_n;
    logic               tmr_expired;
    opcode_e            opcode;
    logic [PAY_W-1:0]   payload;

    assign opcode  = opcode_e'(TABLE_ENTRY[ENTRY_W-1 -: 2]);
    assign payload = TABLE_ENTRY[PAY_W-1:0];

    cfg_tick_timer #(
        .TICK_CYCLES (TICK_CYCLES),
        .N_W         (PAY_W)
    ) u_tmr (
        .clk       (REF_CLK),
        .rst       (RESET_CONFIG),
        .load_i    (tmr_load),
        .n_i       (tmr_n),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        err_idx_d  = err_idx_q;
        retry_d    = retry_q;
        cfg_data_d = cfg_data_q;
        tmr_load   = 1'b0;
        tmr_n      = payload;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (START) begin
                    index_d   = '0;
                    err_idx_d = '0;
                    retry_d   = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                case (opcode)
                    OP_WRITE: begin
                        cfg_data_d = {SLAVE_ADDR, payload};
                        state_d    = S_WAIT_RDY;
                    end
                    OP_DELAY: begin
                        tmr_load = 1'b1;
                        state_d  = S_DLY;
                    end
                    OP_END:   state_d = S_DONE;
                    OP_NOP:   state_d = S_ADV;
                endcase
            end
            S_WAIT_RDY: begin
                if (cfg.CFG_READY) state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT_END;
            S_WAIT_END: begin
                if (cfg.CFG_END) begin
                    if (!cfg.CFG_NACK) begin
                        state_d = S_ADV;
                    end else if (int'(retry_q) < MAX_RETRY) begin
                        retry_d  = retry_q + RC_W'(1);
                        tmr_load = 1'b1;
                        tmr_n    = PAY_W'(RETRY_TICKS);
                        state_d  = S_RWAIT;
                    end else begin
                        err_idx_d = index_q;
                        state_d   = S_FAIL;
                    end
                end
            end
            S_RWAIT: begin
                if (tmr_expired) state_d = S_WAIT_RDY;
            end
            S_DLY: begin
                if (tmr_expired) state_d = S_ADV;
            end
            S_ADV: begin
                retry_d = '0;
                // Running off the end of the table behaves like an END entry.
                if (index_q == IDX_W'(NUM_ENTRIES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge REF_CLK or posedge RESET_CONFIG) begin
        if (RESET_CONFIG) begin
            state_q    <= AUTO_START ? S_FETCH : S_IDLE;
            index_q    <= '0;
            err_idx_q  <= '0;
            retry_q    <= '0;
            cfg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            err_idx_q  <= err_idx_d;
            retry_q    <= retry_d;
            cfg_data_q <= cfg_data_d;
        end
    end

    assign TABLE_INDEX   = index_q;
    assign ERR_INDEX     = err_idx_q;
    assign cfg.CFG_DATA  = cfg_data_q;
    assign cfg.CFG_START = (state_q == S_ISSUE);
    assign DONE          = (state_q == S_DONE);
    assign ERROR         = (state_q == S_FAIL);
    // The reset state may be FETCH, yet BUSY must read 0 while reset is held.
    assign BUSY          = !RESET_CONFIG && (state_q != S_IDLE) &&
                           (state_q != S_DONE) && (state_q != S_FAIL);

endmodule

// File: tb/tb_i2c_config_seq.sv
// Self-checking bench: ROM array, 10-cycle controller model and a transfer
// scoreboard; each scenario task checks its own results.
module tb_i2c_config_seq;
    import i2c_cfg_pkg::*;

    localparam int NE = 8;

    logic        REF_CLK;
    logic        RESET_CONFIG;
    logic        START;
    logic [2:0]  TABLE_INDEX;
    logic [17:0] TABLE_ENTRY;
    logic        BUSY, DONE, ERROR;
    logic [2:0]  ERR_INDEX;

    logic [17:0] rom [NE];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [23:0] exp_q [$];
    logic [23:0] obs_q [$];
    int          st_q  [$];
    int          en_q  [$];
    int          nack_cnt [NE];
    bit          nack_forever [NE];
    bit          mdl_busy;
    int          mdl_cnt;
    int          mdl_cur;

    i2c_config_seq_if #(.CFG_W(24)) ifc ();

    i2c_config_seq #(
        .SLAVE_ADDR  (8'h72),
        .REG_BYTES   (1),
        .DATA_BYTES  (1),
        .NUM_ENTRIES (NE),
        .MAX_RETRY   (3),
        .TICK_CYCLES (10),
        .RETRY_TICKS (1),
        .AUTO_START  (1'b1)
    ) dut (
        .REF_CLK      (REF_CLK),
        .RESET_CONFIG (RESET_CONFIG),
        .START        (START),
        .TABLE_INDEX  (TABLE_INDEX),
        .TABLE_ENTRY  (TABLE_ENTRY),
        .cfg          (ifc),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .ERROR        (ERROR),
        .ERR_INDEX    (ERR_INDEX)
    );

    assign TABLE_ENTRY = rom[TABLE_INDEX];

    initial begin
        REF_CLK = 1'b0;
        forever #5 REF_CLK = ~REF_CLK;
    end

    always @(posedge REF_CLK) cyc <= cyc + 1;

    // Controller model: accepts CFG_START, answers with CFG_END 10 cycles later.
    initial begin
        ifc.CFG_READY = 1'b1;
        ifc.CFG_END   = 1'b0;
        ifc.CFG_NACK  = 1'b0;
        mdl_busy = 1'b0;
        mdl_cnt  = 0;
        mdl_cur  = 0;
        forever begin
            @(negedge REF_CLK);
            ifc.CFG_END  = 1'b0;
            ifc.CFG_NACK = 1'b0;
            if (RESET_CONFIG) begin
                mdl_busy = 1'b0;
                ifc.CFG_READY = 1'b1;
            end else if (mdl_busy) begin
                mdl_cnt--;
                if (mdl_cnt == 0) begin
                    mdl_busy = 1'b0;
                    ifc.CFG_READY = 1'b1;
                    ifc.CFG_END = 1'b1;
                    en_q.push_back(cyc);
                    if (nack_forever[mdl_cur]) begin
                        ifc.CFG_NACK = 1'b1;
                    end else if (nack_cnt[mdl_cur] > 0) begin
                        ifc.CFG_NACK = 1'b1;
                        nack_cnt[mdl_cur]--;
                    end
                end
            end else if (ifc.CFG_START === 1'b1) begin
                mdl_busy = 1'b1;
                ifc.CFG_READY = 1'b0;
                mdl_cnt = 10;
                mdl_cur = int'(TABLE_INDEX);
                obs_q.push_back(ifc.CFG_DATA);
                st_q.push_back(cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    function automatic logic [17:0] ent(opcode_e op, logic [15:0] pay);
        return {op, pay};
    endfunction

    task automatic clear_tables();
        for (int i = 0; i < NE; i++) begin
            rom[i] = ent(OP_NOP, 16'h0000);
            nack_cnt[i] = 0;
            nack_forever[i] = 1'b0;
        end
        exp_q.delete();
        obs_q.delete();
        st_q.delete();
        en_q.delete();
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge REF_CLK);
        START = 1'b0;
    endtask

    task automatic wait_finish();
        for (int i = 0; i < 3000; i++) begin
            if (DONE || ERROR) break;
            @(negedge REF_CLK);
        end
    endtask

    task automatic test_reset();
        RESET_CONFIG = 1'b1;
        START = 1'b0;
        clear_tables();
        repeat (3) @(negedge REF_CLK);
        total++;
        if ({BUSY, DONE, ERROR, ifc.CFG_START} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b required 0000", {BUSY, DONE, ERROR, ifc.CFG_START});
        end
        total++;
        if (ifc.CFG_DATA !== 24'h0) begin
            bad++;
            $display("FAIL reset_cfg_data: got %h required 000000", ifc.CFG_DATA);
        end
        total++;
        if ({TABLE_INDEX, ERR_INDEX} !== 6'b0) begin
            bad++;
            $display("FAIL reset_index: got %0d/%0d required 0/0", TABLE_INDEX, ERR_INDEX);
        end
    endtask

    task automatic test_basic();
        int rel;
        logic [23:0] e, o;
        clear_tables();
        rom[0] = ent(OP_WRITE, 16'h0218);
        rom[1] = ent(OP_WRITE, 16'h1630);
        rom[2] = ent(OP_END, 16'h0000);
        exp_q.push_back(24'h720218);
        exp_q.push_back(24'h721630);
        rel = cyc;
        RESET_CONFIG = 1'b0;
        wait_finish();
        total++;
        if ({DONE, BUSY, ERROR} !== 3'b100) begin
            bad++;
            $display("FAIL basic_status: got done/busy/err=%b required 100", {DONE, BUSY, ERROR});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL basic_xfer: got %h required %h", o, e);
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL basic_extra: got %0d extra transfers required 0", obs_q.size());
        end
        // FETCH, WAIT_RDY, then ISSUE in the third cycle after release.
        total++;
        if ((st_q.size() > 0 ? st_q[0] - rel : -1) != 2) begin
            bad++;
            $display("FAIL basic_latency: got %0d required 2", st_q.size() > 0 ? st_q[0] - rel : -1);
        end
        // END -> ADV, FETCH, WAIT_RDY, ISSUE.
        total++;
        if ((st_q.size() > 1 && en_q.size() > 0 ? st_q[1] - en_q[0] : -1) != 4) begin
            bad++;
            $display("FAIL basic_gap: got %0d required 4",
                     st_q.size() > 1 && en_q.size() > 0 ? st_q[1] - en_q[0] : -1);
        end
    endtask

    task automatic test_delay();
        logic [23:0] e, o;
        clear_tables();
        rom[0] = ent(OP_WRITE, 16'h0218);
        rom[1] = ent(OP_DELAY, 16'd3);
        rom[2] = ent(OP_WRITE, 16'h1630);
        rom[3] = ent(OP_END, 16'h0000);
        exp_q.push_back(24'h720218);
        exp_q.push_back(24'h721630);
        pulse_start();
        wait_finish();
        total++;
        if ({DONE, ERROR} !== 2'b10) begin
            bad++;
            $display("FAIL delay_status: got done/err=%b required 10", {DONE, ERROR});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL delay_xfer: got %h required %h", o, e);
            end
        end
        // ADV, FETCH, 30 DLY cycles, ADV, FETCH, WAIT_RDY, ISSUE = 36.
        total++;
        if ((st_q.size() > 1 && en_q.size() > 0 ? st_q[1] - en_q[0] : -1) != 36) begin
            bad++;
            $display("FAIL delay_gap: got %0d required 36",
                     st_q.size() > 1 && en_q.size() > 0 ? st_q[1] - en_q[0] : -1);
        end
    endtask

    task automatic test_retry();
        logic [23:0] e, o;
        clear_tables();
        rom[0] = ent(OP_WRITE, 16'h0218);
        rom[1] = ent(OP_WRITE, 16'h1630);
        rom[2] = ent(OP_WRITE, 16'h2244);
        rom[3] = ent(OP_END, 16'h0000);
        nack_cnt[2] = 2;
        exp_q.push_back(24'h720218);
        exp_q.push_back(24'h721630);
        repeat (3) exp_q.push_back(24'h722244);
        pulse_start();
        wait_finish();
        total++;
        if ({DONE, ERROR} !== 2'b10) begin
            bad++;
            $display("FAIL retry_status: got done/err=%b required 10", {DONE, ERROR});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL retry_xfer: got %h required %h", o, e);
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL retry_extra: got %0d extra transfers required 0", obs_q.size());
        end
        // NACK END -> 10 RWAIT cycles, WAIT_RDY, ISSUE = 12.
        total++;
        if ((st_q.size() > 3 && en_q.size() > 2 ? st_q[3] - en_q[2] : -1) != 12) begin
            bad++;
            $display("FAIL retry_gap: got %0d required 12",
                     st_q.size() > 3 && en_q.size() > 2 ? st_q[3] - en_q[2] : -1);
        end
    endtask

    task automatic test_fail_restart();
        logic [23:0] e, o;
        clear_tables();
        for (int i = 0; i < 5; i++) rom[i] = ent(OP_WRITE, 16'h1100 + 16'(i));
        rom[5] = ent(OP_END, 16'h0000);
        nack_forever[4] = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(24'h721100 + 24'(i));
        repeat (4) exp_q.push_back(24'h721104);
        pulse_start();
        wait_finish();
        total++;
        if ({DONE, ERROR, BUSY} !== 3'b010) begin
            bad++;
            $display("FAIL fail_status: got done/err/busy=%b required 010", {DONE, ERROR, BUSY});
        end
        total++;
        if (ERR_INDEX !== 3'd4) begin
            bad++;
            $display("FAIL fail_err_index: got %0d required 4", ERR_INDEX);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL fail_xfer: got %h required %h", o, e);
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL fail_extra: got %0d extra transfers required 0", obs_q.size());
        end
        nack_forever[4] = 1'b0;
        obs_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(24'h721100 + 24'(i));
        pulse_start();
        total++;
        if ({ERROR, ERR_INDEX, TABLE_INDEX, BUSY} !== 8'b0_000_000_1) begin
            bad++;
            $display("FAIL restart_clear: got err=%b err_idx=%0d idx=%0d busy=%b required 0/0/0/1",
                     ERROR, ERR_INDEX, TABLE_INDEX, BUSY);
        end
        wait_finish();
        total++;
        if ({DONE, ERROR} !== 2'b10) begin
            bad++;
            $display("FAIL restart_status: got done/err=%b required 10", {DONE, ERROR});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL restart_xfer: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_no_end();
        logic [23:0] e, o;
        clear_tables();
        for (int i = 0; i < NE; i++) begin
            if (i != 3) begin
                rom[i] = ent(OP_WRITE, 16'h3000 + 16'(i));
                exp_q.push_back(24'h723000 + 24'(i));
            end
        end
        pulse_start();
        wait_finish();
        total++;
        if ({DONE, ERROR} !== 2'b10) begin
            bad++;
            $display("FAIL noend_status: got done/err=%b required 10", {DONE, ERROR});
        end
        total++;
        if (TABLE_INDEX !== 3'd7) begin
            bad++;
            $display("FAIL noend_index: got %0d required 7", TABLE_INDEX);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL noend_xfer: got %h required %h", o, e);
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL noend_extra: got %0d extra transfers required 0", obs_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int rel;
        logic [23:0] e, o;
        clear_tables();
        rom[0] = ent(OP_WRITE, 16'h0A01);
        rom[1] = ent(OP_WRITE, 16'h0B02);
        rom[2] = ent(OP_END, 16'h0000);
        exp_q.push_back(24'h720A01);
        exp_q.push_back(24'h720B02);
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            if (st_q.size() >= 2) break;
            @(negedge REF_CLK);
        end
        repeat (3) @(negedge REF_CLK);
        RESET_CONFIG = 1'b1;
        #1;
        total++;
        if ({BUSY, DONE, ERROR, ifc.CFG_START} !== 4'b0000) begin
            bad++;
            $display("FAIL midrst_flags: got %b required 0000", {BUSY, DONE, ERROR, ifc.CFG_START});
        end
        total++;
        if ({ifc.CFG_DATA, TABLE_INDEX} !== 27'h0) begin
            bad++;
            $display("FAIL midrst_data: got data=%h idx=%0d required 000000/0", ifc.CFG_DATA, TABLE_INDEX);
        end
        repeat (2) @(negedge REF_CLK);
        exp_q.push_back(24'h720A01);
        exp_q.push_back(24'h720B02);
        rel = cyc;
        RESET_CONFIG = 1'b0;
        wait_finish();
        total++;
        if ({DONE, ERROR} !== 2'b10) begin
            bad++;
            $display("FAIL midrst_status: got done/err=%b required 10", {DONE, ERROR});
        end
        total++;
        if ((st_q.size() > 2 ? st_q[2] - rel : -1) != 2) begin
            bad++;
            $display("FAIL midrst_latency: got %0d required 2", st_q.size() > 2 ? st_q[2] - rel : -1);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL midrst_xfer: got %h required %h", o, e);
            end
        end
    endtask

    initial begin
        RESET_CONFIG = 1'b1;
        START = 1'b0;
        test_reset();
        test_basic();
        test_delay();
        test_retry();
        test_fail_restart();
        test_no_end();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
